// File: rtl/key_action_sched.sv
// Per-key press/release pulses -> round-robin stream of action tokens.
// Each lane owns its held state and DAS/auto-repeat countdown; the top arbitrates pending events.

module key_action_lane #(
  parameter int CNT_W      = 12,
  parameter int DAS_DELAY  = 170,
  parameter int ARR_PERIOD = 50,
  parameter bit REPEAT     = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic tick,
  input  logic make,
  input  logic brk,
  output logic held,
  output logic evt
);
  logic [CNT_W-1:0] cnt;
  logic             rpt;

  // Any make/break this cycle suppresses the repeat step for the lane.
  assign rpt = REPEAT && held && tick && !make && !brk;
  assign evt = (make && (brk || !held)) || (rpt && cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      held <= 1'b0;
      cnt  <= '0;
    end else if (brk) begin
      held <= 1'b0;
      cnt  <= '0;
    end else if (make) begin
      if (!held) begin
        held <= 1'b1;
        cnt  <= CNT_W'(DAS_DELAY);
      end
    end else if (rpt) begin
      cnt <= (cnt == CNT_W'(1)) ? CNT_W'(ARR_PERIOD) : cnt - CNT_W'(1);
    end
  end
endmodule

module key_action_sched #(
  parameter int                N_KEYS      = 8,
  parameter int                CNT_W       = 12,
  parameter int                DAS_DELAY   = 170,
  parameter int                ARR_PERIOD  = 50,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = 8'h0E,
  localparam int               IDW         = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              tick,
  input  logic [N_KEYS-1:0] key_press,
  input  logic [N_KEYS-1:0] key_release,
  output logic              act_valid,
  output logic [IDW-1:0]    act_id,
  input  logic              act_ready,
  output logic [N_KEYS-1:0] held,
  output logic [7:0]        drop_cnt
);
  logic [N_KEYS-1:0]   evt, pend, clr, rot;
  logic [2*N_KEYS-1:0] pend2;
  logic [IDW-1:0]      grant, rr_ptr;
  logic [7:0]          drop_nxt;
  logic                load, found;
  int                  gi;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_action_lane #(
      .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT(REPEAT_MASK[i])
    ) u_lane (
      .clk(clk), .rst_b(rst_b), .tick(tick),
      .make(key_press[i]), .brk(key_release[i]),
      .held(held[i]), .evt(evt[i])
    );
  end

  // Rotate pend so bit 0 lines up with rr_ptr, then take the first set bit.
  assign pend2 = {pend, pend} >> rr_ptr;
  assign rot   = pend2[N_KEYS-1:0];

  always_comb begin
    grant = '0;
    found = 1'b0;
    gi    = 0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        gi    = int'(rr_ptr) + k;
        if (gi >= N_KEYS) gi = gi - N_KEYS;
        grant = IDW'(gi);
      end
    end
  end

  assign load = (!act_valid || act_ready) && found;

  always_comb begin
    clr = '0;
    if (load) clr[grant] = 1'b1;
  end

  // A new event landing on a still-pending bit is lost; count each such lane.
  always_comb begin
    drop_nxt = drop_cnt;
    for (int k = 0; k < N_KEYS; k++)
      if (evt[k] && pend[k] && !clr[k] && drop_nxt != 8'hFF) drop_nxt = drop_nxt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend      <= '0;
      drop_cnt  <= '0;
      act_valid <= 1'b0;
      act_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      pend     <= evt | (pend & ~clr);
      drop_cnt <= drop_nxt;
      if (load) begin
        act_valid <= 1'b1;
        act_id    <= grant;
        rr_ptr    <= (grant == IDW'(N_KEYS - 1)) ? '0 : grant + IDW'(1);
      end else if (act_ready) begin
        act_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_key_action_sched.sv
// Bench for key_action_sched: vector table, directed multi-cycle scenarios and a
// randomized run compared every cycle against a behavioural model.

module tb_key_action_sched;
  localparam int         N    = 8;
  localparam int         DAS  = 170;
  localparam int         ARR  = 50;
  localparam logic [7:0] MASK = 8'h0E;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] key_press = '0, key_release = '0;
  logic       act_ready = 1'b0;
  logic       act_valid;
  logic [2:0] act_id;
  logic [7:0] held, drop_cnt;

  key_action_sched #(
    .N_KEYS(N), .CNT_W(12), .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst_b(rst_b), .tick(tick), .key_press(key_press), .key_release(key_release),
    .act_valid(act_valid), .act_id(act_id), .act_ready(act_ready),
    .held(held), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0, base = 0;
  int tok_step[$];
  int tok_id[$];

  // Behavioural model state
  bit m_held[];
  bit m_pend[];
  int m_cnt[];
  bit m_valid;
  int m_id, m_rr, m_drop;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_held = new[N];
    m_pend = new[N];
    m_cnt  = new[N];
    m_valid = 0; m_id = 0; m_rr = 0; m_drop = 0;
  endfunction

  function automatic bit bitof(input logic [7:0] v, input int i);
    return ((v >> i) & 8'h1) != 8'h0;
  endfunction

  function automatic void model_step(input logic [7:0] p, input logic [7:0] r,
                                     input logic t, input logic rdy);
    int g;
    bit any;
    bit ev[];
    ev = new[N];
    g = -1;
    any = 0;
    for (int i = 0; i < N; i++) any |= m_pend[i];
    if ((!m_valid || rdy) && any)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) begin
      bit pi, ri;
      pi = bitof(p, i);
      ri = bitof(r, i);
      ev[i] = 0;
      if (ri) begin
        ev[i] = pi;
        m_held[i] = 0;
        m_cnt[i] = 0;
      end else if (pi) begin
        if (!m_held[i]) begin ev[i] = 1; m_held[i] = 1; m_cnt[i] = DAS; end
      end else if (m_held[i] && bitof(MASK, i) && t) begin
        if (m_cnt[i] == 1) begin ev[i] = 1; m_cnt[i] = ARR; end
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit cl;
      cl = (g == i);
      if (ev[i] && m_pend[i] && !cl && m_drop < 255) m_drop++;
      m_pend[i] = ev[i] ? 1'b1 : (cl ? 1'b0 : m_pend[i]);
    end
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_rr = (g + 1) % N;
    end else if (rdy) begin
      m_valid = 0;
    end
  endfunction

  function automatic int model_held();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) if (m_held[i]) v |= (1 << i);
    return v;
  endfunction

  // Called at a negedge: drive, clock, then compare against the model at the next negedge.
  task automatic step(input logic [7:0] p, input logic [7:0] r, input logic t, input logic rdy);
    key_press = p; key_release = r; tick = t; act_ready = rdy;
    if (act_valid && act_ready) begin
      tok_step.push_back(cyc - base);
      tok_id.push_back(int'(act_id));
    end
    @(posedge clk);
    model_step(p, r, t, rdy);
    cyc++;
    @(negedge clk);
    key_press = '0; key_release = '0; tick = 1'b0;
    chk("mdl_valid", int'(act_valid), int'(m_valid));
    chk("mdl_id", int'(act_id), m_id);
    chk("mdl_held", int'(held), model_held());
    chk("mdl_drop", int'(drop_cnt), m_drop);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    key_press = '0; key_release = '0; tick = 1'b0; act_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    tok_step.delete();
    tok_id.delete();
    base = cyc;
  endtask

  typedef struct {
    logic [7:0] p;
    logic [7:0] r;
    logic       rdy;
    logic       vld;
    int         id;
    logic [7:0] hld;
    int         drop;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int exp5[2];
    int exp3[7];
    int exp2[4];

    // p, r, ready -> expected valid, id, held, drop after the edge (tick held low)
    tbl[0]  = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 8'h00, 0};
    tbl[1]  = '{8'h01, 8'h00, 1'b1, 1'b0, 0, 8'h01, 0};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 1'b1, 0, 8'h01, 0};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 8'h01, 0};
    tbl[4]  = '{8'h00, 8'h01, 1'b1, 1'b0, 0, 8'h00, 0};
    tbl[5]  = '{8'h0E, 8'h00, 1'b0, 1'b0, 0, 8'h0E, 0};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1, 8'h0E, 0};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1, 8'h0E, 0};
    tbl[8]  = '{8'h04, 8'h04, 1'b0, 1'b1, 1, 8'h0A, 1};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1, 2, 8'h0A, 1};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b1, 3, 8'h0A, 1};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 3, 8'h0A, 1};
    tbl[12] = '{8'h81, 8'h00, 1'b1, 1'b0, 3, 8'h8B, 1};
    tbl[13] = '{8'h00, 8'h00, 1'b1, 1'b1, 7, 8'h8B, 1};
    tbl[14] = '{8'h00, 8'h00, 1'b1, 1'b1, 0, 8'h8B, 1};
    tbl[15] = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 8'h8B, 1};

    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_valid", int'(act_valid), 0);
    chk("rst_id", int'(act_id), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    for (int v = 0; v < 16; v++) begin
      step(tbl[v].p, tbl[v].r, 1'b0, tbl[v].rdy);
      chk($sformatf("tbl%0d_valid", v), int'(act_valid), int'(tbl[v].vld));
      chk($sformatf("tbl%0d_id", v), int'(act_id), tbl[v].id);
      chk($sformatf("tbl%0d_held", v), int'(held), int'(tbl[v].hld));
      chk($sformatf("tbl%0d_drop", v), int'(drop_cnt), tbl[v].drop);
    end

    // Non-repeat lane: exactly one token, two cycles after the press.
    do_reset();
    for (int s = 0; s < 1002; s++) begin
      step(s == 0 ? 8'h01 : 8'h00, 8'h00, 1'b1, 1'b1);
      if (s == 0) chk("s1_valid_e0", int'(act_valid), 0);
      if (s == 1) begin
        chk("s1_valid_e1", int'(act_valid), 1);
        chk("s1_id_e1", int'(act_id), 0);
      end
    end
    chk("s1_ntok", tok_step.size(), 1);
    if (tok_step.size() > 0) chk("s1_tokstep", tok_step[0], 2);

    // Repeat lane: events at ticks 0,170,220,270; release at 300.
    do_reset();
    for (int s = 0; s < 400; s++)
      step(s == 0 ? 8'h02 : 8'h00, s == 300 ? 8'h02 : 8'h00, 1'b1, 1'b1);
    exp2 = '{2, 172, 222, 272};
    chk("s2_ntok", tok_step.size(), 4);
    for (int k = 0; k < 4 && k < tok_step.size(); k++) begin
      chk($sformatf("s2_step%0d", k), tok_step[k], exp2[k]);
      chk($sformatf("s2_id%0d", k), tok_id[k], 1);
    end

    // Simultaneous presses, then a second burst resuming above the last grant.
    do_reset();
    step(8'h0E, 8'h00, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h00, 8'h0E, 1'b0, 1'b1);
    step(8'h65, 8'h00, 1'b0, 1'b1);
    for (int s = 0; s < 6; s++) step(8'h00, 8'h00, 1'b0, 1'b1);
    exp3 = '{1, 2, 3, 5, 6, 0, 2};
    chk("s3_ntok", tok_id.size(), 7);
    for (int k = 0; k < 7 && k < tok_id.size(); k++)
      chk($sformatf("s3_id%0d", k), tok_id[k], exp3[k]);
    if (tok_step.size() >= 3) chk("s3_consec", tok_step[2] - tok_step[0], 2);
    if (tok_step.size() >= 7) chk("s3_consec2", tok_step[6] - tok_step[3], 3);

    // Stalled consumer: token held stable, third press of the lane coalesces.
    do_reset();
    for (int s = 0; s < 20; s++) begin
      logic [7:0] p, r;
      p = (s == 0 || s == 3 || s == 6) ? 8'h04 : 8'h00;
      r = (s == 2 || s == 5) ? 8'h04 : 8'h00;
      step(p, r, 1'b0, 1'b0);
      if (s >= 1) begin
        chk("s4_valid", int'(act_valid), 1);
        chk("s4_id", int'(act_id), 2);
      end
      if (s == 3) chk("s4_drop_mid", int'(drop_cnt), 0);
      if (s == 6) chk("s4_drop", int'(drop_cnt), 1);
    end
    for (int s = 0; s < 5; s++) step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("s4_ntok", tok_id.size(), 2);

    // Typematic makes while held: no tokens, no reload (ticks on even cycles only).
    do_reset();
    for (int s = 0; s < 500; s++) begin
      logic [7:0] p;
      p = (s == 0 || (s % 30 == 1 && s < 450)) ? 8'h02 : 8'h00;
      step(p, s == 450 ? 8'h02 : 8'h00, (s % 2) == 0, 1'b1);
    end
    exp5 = '{342, 442};
    chk("s5_ntok", tok_step.size(), 3);
    if (tok_step.size() > 0) chk("s5_step0", tok_step[0], 2);
    for (int k = 0; k < 2 && k + 1 < tok_step.size(); k++)
      chk($sformatf("s5_step%0d", k + 1), tok_step[k + 1], exp5[k]);

    // Asynchronous reset mid-repeat with a stalled token.
    do_reset();
    for (int s = 0; s < 225; s++) step(s == 0 ? 8'h02 : 8'h00, 8'h00, 1'b1, 1'b0);
    chk("s6_pre_valid", int'(act_valid), 1);
    chk("s6_pre_drop", int'(drop_cnt), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("s6_async_valid", int'(act_valid), 0);
    chk("s6_async_id", int'(act_id), 0);
    chk("s6_async_held", int'(held), 0);
    chk("s6_async_drop", int'(drop_cnt), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    tok_step.delete();
    tok_id.delete();
    base = cyc;
    for (int s = 0; s < 300; s++) step(8'h00, 8'h00, 1'b1, 1'b1);
    chk("s6_no_tok", tok_id.size(), 0);
    step(8'h02, 8'h00, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) step(8'h00, 8'h00, 1'b1, 1'b1);
    chk("s6_new_tok", tok_id.size(), 1);

    // Randomized traffic against the model, alternating consumer pressure.
    do_reset();
    for (int s = 0; s < 4000; s++) begin
      logic [7:0] p, r;
      logic rdy;
      p = '0;
      r = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) p |= (8'h01 << i);
        if ($urandom_range(0, 199) == 0) r |= (8'h01 << i);
      end
      rdy = ((s / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      step(p, r, $urandom_range(0, 2) == 0, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
